field_unpacker: RTL and testbench

FIELD_UNPACKER -- requirements
Module: field_unpacker

---
 rtl/field_unpacker.sv | 116 +++++++++++
 tb/tb_field_unpacker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_unpacker.sv
// Field unpacker: buffers N-bit MSB-first words and emits 24/15/9-bit fields.
// Ports: clk, rst (async low), mode, in_valid/in_ready/data_in, out_valid/
//   out_ready/field_out, flush, count, mode_err, field_cnt.
// Macro FIELD_UNPACKER_STATS_EN enables the delivered-field counter.
module field_unpacker #(
   parameter int N     = 64,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [23:0]      field_out,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             mode_err,
   output logic [15:0]      field_cnt
);

   logic [2*N-1:0]   buf_q, buf_d, buf_sh, app;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_x;
   logic             ov_q;
   logic [23:0]      fo_q, fo_d;
   logic             err_q;
   logic [4:0]       wv;
   logic             rsv, can, ld, acc;
   logic [23:0]      top;

   assign in_ready  = (cnt_q <= CNT_W'(N)) && !flush;
   assign out_valid = ov_q;
   assign field_out = fo_q;
   assign count     = cnt_q;
   assign mode_err  = err_q;

   always_comb begin
      wv  = 5'd0;
      rsv = 1'b0;
      case (mode)
         3'd0:    wv  = 5'd24;
         3'd1:    wv  = 5'd15;
         3'd2:    wv  = 5'd9;
         default: rsv = 1'b1;
      endcase
   end

   assign top = buf_q[2*N-1 -: 24];

   always_comb begin
      fo_d = top;
      case (mode)
         3'd1:    fo_d = {9'd0, top[23:9]};
         3'd2:    fo_d = {15'd0, top[23:15]};
         default: fo_d = top;
      endcase
   end

   // Load decision uses the pre-append occupancy.
   assign can = !ov_q || out_ready;
   assign ld  = can && !rsv && (cnt_q >= CNT_W'(wv));
   assign acc = in_valid && in_ready;

   // Extract first, then place the new word directly below what remains.
   always_comb begin
      buf_sh = ld ? (buf_q << wv) : buf_q;
      cnt_x  = ld ? (cnt_q - CNT_W'(wv)) : cnt_q;
      app    = {data_in, {N{1'b0}}} >> cnt_x;
      buf_d  = acc ? (buf_sh | app) : buf_sh;
      cnt_d  = acc ? (cnt_x + CNT_W'(N)) : cnt_x;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q <= '0;
         cnt_q <= '0;
         ov_q  <= 1'b0;
         fo_q  <= '0;
         err_q <= 1'b0;
      end else if (flush) begin
         buf_q <= '0;
         cnt_q <= '0;
         ov_q  <= 1'b0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         if (can && rsv)
            err_q <= 1'b1;
         if (ld) begin
            fo_q <= fo_d;
            ov_q <= 1'b1;
         end else if (ov_q && out_ready) begin
            ov_q <= 1'b0;
         end
      end
   end

`ifdef FIELD_UNPACKER_STATS_EN
   logic [15:0] fc_q;

   // A handshake on a flush edge still counts: the consumer took the field.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fc_q <= '0;
      else if (ov_q && out_ready)
         fc_q <= fc_q + 16'd1;
   end

   assign field_cnt = fc_q;
`else
   assign field_cnt = '0;
`endif

endmodule

// File: tb/tb_field_unpacker.sv
// Testbench for field_unpacker: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_field_unpacker;

   localparam int N  = 64;
   localparam int CW = 8;
   localparam logic [63:0] WA = 64'hABCDEF0123456789;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    mode;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  data_in;
   logic          out_valid;
   logic          out_ready;
   logic [23:0]   field_out;
   logic          flush;
   logic [CW-1:0] count;
   logic          mode_err;
   logic [15:0]   field_cnt;

   always #5 clk = ~clk;

   field_unpacker #(.N(N), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .field_out (field_out),
      .flush     (flush),
      .count     (count),
      .mode_err  (mode_err),
      .field_cnt (field_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   bit          q[$];
   bit          mv;
   logic [23:0] mf;
   bit          merr;
   int          mfc;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   task automatic mreset();
      q.delete();
      mv   = 0;
      mf   = '0;
      merr = 0;
      mfc  = 0;
   endtask

   function automatic int width_of(input logic [2:0] m);
      if (m == 3'd0) return 24;
      if (m == 3'd1) return 15;
      if (m == 3'd2) return 9;
      return 0;
   endfunction

   task automatic check_all();
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("field_out", 64'(field_out), 64'(mf));
      chk("mode_err", 64'(mode_err), 64'(merr));
`ifdef FIELD_UNPACKER_STATS_EN
      chk("field_cnt", 64'(field_cnt), 64'(mfc & 16'hFFFF));
`else
      chk("field_cnt", 64'(field_cnt), 64'd0);
`endif
   endtask

   task automatic cyc(input logic f, input logic v, input logic [63:0] d,
                      input logic [2:0] m, input logic r);
      bit rdy;
      int w;
      bit can;
      logic [23:0] fv;
      @(negedge clk);
      flush     = f;
      in_valid  = v;
      data_in   = d;
      mode      = m;
      out_ready = r;
      #1;
      rdy = (q.size() <= N) && !f;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      @(posedge clk);
      if (mv && r) mfc++;
      if (f) begin
         q.delete();
         mv = 0;
      end else begin
         w   = width_of(m);
         can = !mv || r;
         if (can && w == 0) merr = 1;
         if (can && w != 0 && q.size() >= w) begin
            fv = '0;
            repeat (w) fv = {fv[22:0], q.pop_front()};
            mf = fv;
            mv = 1;
         end else if (mv && r) begin
            mv = 0;
         end
         if (v && rdy)
            for (int i = N - 1; i >= 0; i--) q.push_back(d[i]);
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      mreset();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovalid", 64'(out_valid), 64'd0);
      chk("rst_field", 64'(field_out), 64'd0);
      chk("rst_iready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      mode      = 3'd0;
      in_valid  = 1'b0;
      data_in   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;

      // mode 0 extraction
      cyc(0, 1, WA, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("m0_f1", 64'(field_out), 64'hABCDEF);
      cyc(0, 0, 0, 0, 1);
      chk("m0_f2", 64'(field_out), 64'h012345);
      cyc(0, 0, 0, 0, 1);
      chk("m0_left", 64'(count), 64'd16);
      cyc(1, 0, 0, 0, 1);

      // mode 2 extraction
      cyc(0, 1, 64'h8000000000000000, 2, 1);
      cyc(0, 0, 0, 2, 1);
      chk("m2_f1", 64'(field_out), 64'h100);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0, 2, 1);
         chk("m2_fz", 64'(field_out), 64'h0);
      end
      cyc(0, 0, 0, 2, 1);
      chk("m2_left", 64'(count), 64'd1);
      cyc(1, 0, 0, 0, 1);

      // backpressure
      cyc(0, 1, WA, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 64'(i) * 64'h1111111111111111, 0, 0);
         chk("bp_hold", 64'(field_out), 64'hABCDEF);
      end
      chk("bp_full", 64'(in_ready), 64'd0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

      // reset mid-stream
      cyc(0, 1, WA, 0, 0);
      cyc(0, 0, 0, 0, 0);
      do_reset();

      // reserved mode
      cyc(0, 1, WA, 5, 1);
      cyc(0, 0, 0, 5, 1);
      chk("rsv_ovalid", 64'(out_valid), 64'd0);
      chk("rsv_err", 64'(mode_err), 64'd1);
      cyc(0, 0, 0, 0, 1);
      chk("rsv_sticky", 64'(mode_err), 64'd1);
      chk("rsv_f", 64'(field_out), 64'hABCDEF);

`ifdef FIELD_UNPACKER_STATS_EN
      do_reset();
      cyc(0, 1, WA, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, WA, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      chk("st_flush_cnt", 64'(count), 64'd0);
      cyc(0, 1, WA, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("st_fields", 64'(field_cnt), 64'd5);
`endif

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] m;
         m = ($urandom_range(0, 199) == 0) ? 3'(3 + $urandom_range(0, 4))
                                           : 3'($urandom_range(0, 2));
         cyc(1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 9) < 7),
             {$urandom, $urandom},
             m,
             1'($urandom_range(0, 9) < 6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
